// File: rtl/seg7_pattern_decoder.sv
// Reverse 7-segment decoder: glitch-filters SEG, emits one event per
// newly stable glyph over VALID/READY, and counts error glyphs.
module seg7_pattern_decoder #(
   parameter int STABLE_CYCLES = 4,
   parameter int ERR_CNT_W     = 8
) (
   input  logic                 CLK,
   input  logic                 RST,
   input  logic [6:0]           SEG,
   input  logic                 READY,
   output logic                 VALID,
   output logic [1:0]           CODE,
   output logic                 ERR,
   output logic                 INVALID,
   output logic [ERR_CNT_W-1:0] ERR_COUNT
);

   localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   localparam logic [6:0] GLYPH_1 = 7'b0110000;
   localparam logic [6:0] GLYPH_2 = 7'b1101101;
   localparam logic [6:0] GLYPH_3 = 7'b1111001;
   localparam logic [6:0] GLYPH_E = 7'b1001111;

   typedef enum logic {
      IDLE,
      PEND
   } state_t;

   typedef struct packed {
      logic [1:0] code;
      logic       err;
      logic       invalid;
   } event_t;

   state_t               state_q, state_d;
   logic [6:0]           s1_q, s1_d;
   logic [6:0]           last_q, last_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   event_t               evt_q, evt_d;
   logic [ERR_CNT_W-1:0] err_count_q, err_count_d;

   event_t dec;
   logic   stable;
   logic   slot_free;
   logic   accept;
   logic   blank_seen;

   always_comb begin
      dec = '0;
      unique case (1'b1)
         (s1_q == GLYPH_1): dec.code = 2'b01;
         (s1_q == GLYPH_2): dec.code = 2'b10;
         (s1_q == GLYPH_3): dec.code = 2'b11;
         (s1_q == GLYPH_E): dec.err  = 1'b1;
         default:           dec.invalid = (s1_q != 7'd0);
      endcase
   end

   always_comb begin
      stable     = (cnt_q == CNT_MAX);
      slot_free  = (state_q == IDLE) || READY;
      accept     = stable && (s1_q != 7'd0) &&
                   (s1_q != last_q) && slot_free;
      blank_seen = stable && (s1_q == 7'd0);
   end

   always_comb begin
      s1_d = SEG;
      if (SEG == s1_q) begin
         cnt_d = stable ? cnt_q : cnt_q + CNT_ONE;
      end else begin
         cnt_d = CNT_ONE;
      end
   end

   // A stable blank re-arms the same glyph even while the slot is busy.
   always_comb begin
      last_d      = last_q;
      evt_d       = evt_q;
      err_count_d = err_count_q;
      if (blank_seen) begin
         last_d = 7'd0;
      end
      if (accept) begin
         last_d = s1_q;
         evt_d  = dec;
         if ((dec.err || dec.invalid) && (err_count_q != '1)) begin
            err_count_d = err_count_q + 1'b1;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            if (accept) state_d = PEND;
         end
         PEND: begin
            if (READY && !accept) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q     <= IDLE;
         s1_q        <= '0;
         cnt_q       <= '0;
         last_q      <= '0;
         evt_q       <= '0;
         err_count_q <= '0;
      end else begin
         state_q     <= state_d;
         s1_q        <= s1_d;
         cnt_q       <= cnt_d;
         last_q      <= last_d;
         evt_q       <= evt_d;
         err_count_q <= err_count_d;
      end
   end

   assign VALID     = (state_q == PEND);
   assign CODE      = evt_q.code;
   assign ERR       = evt_q.err;
   assign INVALID   = evt_q.invalid;
   assign ERR_COUNT = err_count_q;

endmodule

// File: doc/seg7_pattern_decoder.md
# seg7_pattern_decoder

Recovers the 2-bit code from a 7-segment pattern bus driven by the display decoder, which maps code 01/10/11 to glyphs '1'/'2'/'3' and code 00 to the 'E' error glyph. It performs the reverse mapping. The block filters the segment bus for glitches, emits one event per newly stable glyph through a valid/ready handshake, and counts error and unrecognised glyphs. It sits on the readback/self-check path beside the display driver. It lets the controller confirm what the display is actually showing.

## Interface
Parameters:
- STABLE_CYCLES, default 4: number of consecutive identical samples required before a pattern is accepted. Legal range is 2..255.
- ERR_CNT_W, default 8: width of the saturating error counter.

Ports:
- CLK, in, 1: the single clock. All state updates on the rising edge.
- RST, in, 1: reset, synchronous and active-high.
- SEG, in, 7: segment pattern {a,b,c,d,e,f,g}, with bit6 = a and bit0 = g. Active-high.
- READY, in, 1: the consumer accepts the current event.
- VALID, out, 1: an event is pending on CODE/ERR/INVALID.
- CODE, out, 2: decoded code.
- ERR, out, 1: the event is the 'E' glyph.
- INVALID, out, 1: the event is an unrecognised non-blank pattern.
- ERR_COUNT, out, ERR_CNT_W: count of accepted ERR plus INVALID events. Saturates at all-ones.

## Operation
- Glyph map:
  - 0110000 gives CODE 01.
  - 1101101 gives CODE 10.
  - 1111001 gives CODE 11.
  - 1001111 gives CODE 00 with ERR=1.
  - Any other non-zero pattern gives CODE 00 with INVALID=1.
  - 0000000 (blank) produces no event.
  - ERR and INVALID are never both 1.
- Sample register s1 and run counter cnt (width clog2(STABLE_CYCLES+1)) update every edge:
  - If SEG == s1: cnt <= min(cnt+1, STABLE_CYCLES).
  - Otherwise: cnt <= 1.
  - In both cases: s1 <= SEG.
- last holds the most recently accepted pattern. It is 0 after reset.
- Accept condition: cnt == STABLE_CYCLES, s1 != 0, s1 != last, and the output slot is free.
  - The slot is free when VALID == 0, or when VALID && READY in the same cycle.
  - On accept: load CODE/ERR/INVALID from s1, set VALID=1, set last <= s1.
  - If the decoded event is ERR or INVALID, also increment ERR_COUNT (saturating).
- Blank: when cnt == STABLE_CYCLES and s1 == 0, set last <= 0. This happens regardless of slot state. It re-arms the block so the same glyph shown again after a blank produces a new event.
- Output control has two states:
  - IDLE (VALID=0) moves to PEND on accept.
  - PEND (VALID=1) moves to IDLE when VALID && READY and there is no accept in the same edge.
  - PEND stays in PEND when VALID && READY and there is an accept in the same edge (back-to-back event).
- While in PEND with READY=0, CODE/ERR/INVALID hold constant. A qualifying new pattern waits, because cnt stays saturated. It is accepted at the first edge where the slot frees, provided it is still stable and still differs from last.
- A glitch shorter than STABLE_CYCLES samples never produces an event. It does restart the run counter.
- Reset mid-operation: a pending event is discarded with no handshake. Counters and state clear.

## Timing
- Reset values:
  - VALID=0, CODE=00, ERR=0, INVALID=0, ERR_COUNT=0.
  - Internal state: s1=0, cnt=0, last=0.
- Latency: SEG changes to a new stable non-blank glyph before edge k and holds. cnt reaches STABLE_CYCLES at edge k+STABLE_CYCLES-1. VALID is high after edge k+STABLE_CYCLES.
- Handshake:
  - Transfer occurs on an edge with VALID && READY.
  - With no back-to-back accept, VALID is low after that edge.
  - READY is ignored while VALID=0.
  - ERR_COUNT updates on the same edge that VALID rises.
- Maximum throughput: one event per STABLE_CYCLES cycles, since each new glyph must re-establish stability.

## Test plan
- Reset, then hold SEG=0110000 with READY=1 and STABLE_CYCLES=4. VALID pulses for 1 cycle, 4 edges after first sample, with CODE=01, ERR=0, INVALID=0. No further event while SEG is held.
- Sequence '2', '3', 'E', 1111111, each held 6 cycles, with READY=1. Events are CODE 10, then 11, then 00/ERR=1, then 00/INVALID=1. ERR_COUNT ends at 2.
- SEG='1' for 3 cycles, then '2' for 6 cycles. There is exactly one event, CODE=10. Same test with a 1-cycle '3' glitch inside a '2' run: still only one event, CODE=10.
- Present '1', blank for 6 cycles, then '1' again. Two CODE=01 events. '1' then '1' with no blank gives only one event.
- Hold READY=0, present '2' then '3'. VALID stays high with CODE=10 held. Raise READY for 1 cycle: CODE=11 is loaded on that same edge and VALID stays 1.
- Assert RST while VALID=1 and ERR_COUNT=3. After the edge, VALID=0, CODE=00, ERR_COUNT=0. With SEG held at the same glyph, a fresh event fires STABLE_CYCLES edges after release. With ERR_CNT_W=2, five 'E' events saturate ERR_COUNT at 3.
